// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, per-channel stability counter, level and edge pulses.
// Define BTN_DEBOUNCE_AUTOREPEAT_EN to add periodic btn_rise pulses while a button stays held.
module btn_debounce #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_rise,
  output logic [N-1:0] btn_fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Bit 1 of the state is the accepted level; bit 0 marks a pending change.
  localparam logic [1:0] S_IDLE         = 2'b00;
  localparam logic [1:0] S_PRESS_PEND   = 2'b01;
  localparam logic [1:0] S_HELD         = 2'b10;
  localparam logic [1:0] S_RELEASE_PEND = 2'b11;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("btn_debounce: illegal parameter value");
  end

  logic [N-1:0]         sync1;
  logic [N-1:0]         sync2;
  logic [N-1:0][1:0]    state;
  logic [N-1:0][1:0]    state_nxt;
  logic [N-1:0][CW-1:0] cnt;
  logic [N-1:0][CW-1:0] cnt_nxt;
  logic [N-1:0]         rise_nxt;
  logic [N-1:0]         fall_nxt;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [HW-1:0] DELAY_MAX  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_MAX = HW'(REPEAT_PERIOD - 1);

  logic [N-1:0][HW-1:0] hold;
  logic [N-1:0][HW-1:0] hold_nxt;
  logic [N-1:0]         rep_phase;
  logic [N-1:0]         rep_phase_nxt;
`endif

  always_comb begin
    for (int i = 0; i < N; i++) begin
      btn_level[i] = state[i][1];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = '0;
    fall_nxt  = '0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    hold_nxt      = '0;
    rep_phase_nxt = '0;
`endif
    for (int i = 0; i < N; i++) begin
      case (state[i])
        S_IDLE: begin
          if (sync2[i]) begin
            cnt_nxt[i]   = cnt[i] + 1'b1;
            state_nxt[i] = S_PRESS_PEND;
          end else begin
            cnt_nxt[i]   = '0;
          end
        end
        S_PRESS_PEND: begin
          if (!sync2[i]) begin
            cnt_nxt[i]   = '0;
            state_nxt[i] = S_IDLE;
          end else if (cnt[i] == CNT_MAX) begin
            cnt_nxt[i]   = '0;
            state_nxt[i] = S_HELD;
            rise_nxt[i]  = 1'b1;
          end else begin
            cnt_nxt[i]   = cnt[i] + 1'b1;
          end
        end
        S_HELD: begin
          if (!sync2[i]) begin
            cnt_nxt[i]   = cnt[i] + 1'b1;
            state_nxt[i] = S_RELEASE_PEND;
          end else begin
            cnt_nxt[i]   = '0;
          end
        end
        S_RELEASE_PEND: begin
          if (sync2[i]) begin
            cnt_nxt[i]   = '0;
            state_nxt[i] = S_HELD;
          end else if (cnt[i] == CNT_MAX) begin
            cnt_nxt[i]   = '0;
            state_nxt[i] = S_IDLE;
            fall_nxt[i]  = 1'b1;
          end else begin
            cnt_nxt[i]   = cnt[i] + 1'b1;
          end
        end
      endcase
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
      // Hold counter runs only while the accepted level is high; a release on a repeat point wins.
      if (state[i][1]) begin
        rep_phase_nxt[i] = rep_phase[i];
        hold_nxt[i]      = hold[i] + 1'b1;
        if (hold[i] == (rep_phase[i] ? PERIOD_MAX : DELAY_MAX)) begin
          hold_nxt[i]      = '0;
          rep_phase_nxt[i] = 1'b1;
          rise_nxt[i]      = ~fall_nxt[i];
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      state     <= '0;
      cnt       <= '0;
      btn_rise  <= '0;
      btn_fall  <= '0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
      hold      <= '0;
      rep_phase <= '0;
`endif
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_rise  <= rise_nxt;
      btn_fall  <= fall_nxt;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
      hold      <= hold_nxt;
      rep_phase <= rep_phase_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: hand-derived vector table, corner sequences and random stimulus
// against a sample-window reference model.
module tb_btn_debounce;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int W  = 3 * N;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] raw;
    int           cycles;
    logic [N-1:0] lvl;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } vec_t;

  // clock / reset
  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_rise;
  logic [N-1:0] btn_fall;

  always #5 clk = ~clk;

  btn_debounce #(
    .N(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall)
  );

  // scoreboard and reference model state
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  logic [N-1:0] samp_q[$];
  logic [N-1:0] m_level;
  int           edge_n;
  int           press_edge[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_level = '0;
    edge_n  = 0;
    samp_q.delete();
    exp_q.delete();
    for (int k = 0; k < D + 2; k++) samp_q.push_back('0);
    for (int c = 0; c < N; c++) press_edge[c] = 0;
  endtask

  // A level flips when the D most recent synchronised samples (raw delayed two edges) all disagree with it.
  task automatic model_edge(input logic [N-1:0] raw);
    logic [N-1:0] r;
    logic [N-1:0] f;
    logic [N-1:0] s;
    bit           flip;
    int           el;
    r = '0;
    f = '0;
    edge_n++;
    samp_q.push_back(raw);
    while (samp_q.size() > D + 2) void'(samp_q.pop_front());
    for (int c = 0; c < N; c++) begin
      flip = 1'b1;
      for (int k = 0; k < D; k++) begin
        s = samp_q[k];
        if (s[c] == m_level[c]) flip = 1'b0;
      end
      if (flip) begin
        if (m_level[c]) f[c] = 1'b1;
        else begin
          r[c] = 1'b1;
          press_edge[c] = edge_n;
        end
        m_level[c] = ~m_level[c];
      end else if (AUTOREP && m_level[c]) begin
        el = edge_n - press_edge[c];
        if (el >= RD && (el - RD) % RP == 0) r[c] = 1'b1;
      end
    end
    exp_q.push_back({m_level, r, f});
  endtask

  // driver tasks
  task automatic tick(input logic [N-1:0] raw);
    logic [W-1:0] exp_v;
    btn_raw = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    exp_v = exp_q.pop_front();
    check("model_step", 64'({btn_level, btn_rise, btn_fall}), 64'(exp_v));
  endtask

  task automatic apply_reset(input logic [N-1:0] raw);
    btn_raw = raw;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("reset_outputs", 64'({btn_level, btn_rise, btn_fall}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         vecs[8];
    int           first;
    int           n_pulse;
    logic [63:0]  rep_mask;
    logic [63:0]  rep_exp;
    logic [N-1:0] cur;

    vecs[0] = '{raw: 4'b0000, cycles: 3,  lvl: 4'b0000, rise: 4'b0000, fall: 4'b0000};
    vecs[1] = '{raw: 4'b0010, cycles: 10, lvl: 4'b0010, rise: 4'b0010, fall: 4'b0000};
    vecs[2] = '{raw: 4'b0010, cycles: 2,  lvl: 4'b0010, rise: 4'b0000, fall: 4'b0000};
    vecs[3] = '{raw: 4'b0110, cycles: 7,  lvl: 4'b0010, rise: 4'b0000, fall: 4'b0000};
    vecs[4] = '{raw: 4'b0010, cycles: 10, lvl: 4'b0010, rise: 4'b0000, fall: 4'b0000};
    vecs[5] = '{raw: 4'b1001, cycles: 10, lvl: 4'b1001, rise: 4'b1001, fall: 4'b0010};
    vecs[6] = '{raw: 4'b1001, cycles: 1,  lvl: 4'b1001, rise: 4'b0000, fall: 4'b0000};
    vecs[7] = '{raw: 4'b0000, cycles: 10, lvl: 4'b0000, rise: 4'b0000, fall: 4'b1001};

    // Reset with every button held, then re-debounce from zero.
    apply_reset(4'hF);
    first = -1;
    for (int k = 1; k <= 20 && first < 0; k++) begin
      tick(4'hF);
      if (btn_rise == 4'hF) begin
        first = k;
        check("reset_hold_level", 64'(btn_level), 64'hF);
      end
    end
    check("reset_hold_latency", 64'(first), 64'd10);
    repeat (12) tick(4'h0);

    // Vector table: expected values are taken at the last cycle of each stretch.
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < vecs[v].cycles; k++) tick(vecs[v].raw);
      check($sformatf("vec%0d", v), 64'({btn_level, btn_rise, btn_fall}),
            64'({vecs[v].lvl, vecs[v].rise, vecs[v].fall}));
    end

    // Bounce on channel 0: 3 high / 2 low for 30 cycles, then stable high.
    n_pulse = 0;
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 5; k++) begin
        tick((k < 3) ? 4'b0001 : 4'b0000);
        if (btn_rise != '0) n_pulse++;
      end
    end
    check("bounce_no_pulse", 64'(n_pulse), 64'd0);
    first = -1;
    for (int k = 1; k <= 20 && first < 0; k++) begin
      tick(4'b0001);
      if (btn_rise[0]) first = k;
    end
    check("bounce_latency", 64'(first), 64'd10);

    // Hold 40 cycles past acceptance and record repeat offsets.
    rep_mask = '0;
    for (int k = 1; k <= 40; k++) begin
      tick(4'b0001);
      if (btn_rise[0]) rep_mask[k] = 1'b1;
    end
    rep_exp = AUTOREP ? ((64'd1 << 20) | (64'd1 << 25) | (64'd1 << 30) | (64'd1 << 35) | (64'd1 << 40))
                      : 64'd0;
    check("autorepeat_offsets", rep_mask, rep_exp);
    check("held_level", 64'(btn_level), 64'd1);
    repeat (12) tick(4'h0);

    // Reset in the middle of a pending count while other buttons are held.
    repeat (10) tick(4'b0100);
    check("midop_pre_level", 64'(btn_level), 64'b0100);
    repeat (5) tick(4'b1100);
    apply_reset(4'b1100);
    first = -1;
    for (int k = 1; k <= 20 && first < 0; k++) begin
      tick(4'b1100);
      if (btn_rise == 4'b1100) first = k;
    end
    check("midop_rearm_latency", 64'(first), 64'd10);
    repeat (12) tick(4'h0);

    // Random toggling with runs around the debounce length, plus one async reset.
    cur = '0;
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 9) == 0) cur[c] = ~cur[c];
      end
      if (k == 400) apply_reset(cur);
      tick(cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
